// File: rtl/dm_resp_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM encoding, the wait-counter width and the byte-lane merge.
package dm_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_W = 4;

    // Lanes with be[i]=1 take the new byte; all other lanes keep the old byte.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dm_resp_array.sv
// Single-port 2^ADDR_W x 32 word array with byte-enable writes.
// The registered output returns the word as it stands after the access.
module dm_resp_array
    import dm_resp_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        be,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];
    logic [31:0] rdata_reg;
    logic [31:0] merged;

    // A read is a merge with no lanes enabled, so it yields the stored word.
    assign merged = byte_merge(mem[addr], wdata, we ? be : 4'b0000);

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= merged;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_reg <= '0;
        end else if (en) begin
            rdata_reg <= merged;
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/dm_resp.sv
// Data-memory responder for the MEM stage: one access at a time with a
// configurable number of wait states, a one-cycle rvalid and a stall request.
module dm_resp
    import dm_resp_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        be,
    output logic              ready,
    output logic              rvalid,
    output logic [31:0]       rdata,
    output logic              stall
);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               we_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [31:0]        wdata_reg;
    logic [3:0]         be_reg;
    logic               accept;
    logic               commit;
    logic               c_we;
    logic [ADDR_W-1:0]  c_addr;
    logic [31:0]        c_wdata;
    logic [3:0]         c_be;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                we_reg    <= we;
                addr_reg  <= addr;
                wdata_reg <= wdata;
                be_reg    <= be;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ready      = 1'b0;
        rvalid     = 1'b0;
        stall      = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (req) begin
                    stall  = 1'b1;
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                stall    = 1'b1;
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rvalid     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // With zero wait states the commit shares the accept edge, so the live
    // request fields must feed the array instead of the latched copies.
    assign commit  = (state_next == RESP) && (state_reg != RESP) && rst;
    assign c_we    = (state_reg == IDLE) ? we    : we_reg;
    assign c_addr  = (state_reg == IDLE) ? addr  : addr_reg;
    assign c_wdata = (state_reg == IDLE) ? wdata : wdata_reg;
    assign c_be    = (state_reg == IDLE) ? be    : be_reg;

    dm_resp_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (commit),
        .we    (c_we),
        .addr  (c_addr),
        .wdata (c_wdata),
        .be    (c_be),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_dm_resp.sv
// Randomized self-checking bench for dm_resp: one instance with two wait
// states and one with none, both checked against a word-array model.
module tb_dm_resp;

    localparam int AW = 10;

    logic        clk;
    logic        rst;
    logic        req_v   [2];
    logic        we_v    [2];
    logic [AW-1:0] addr_v [2];
    logic [31:0] wdata_v [2];
    logic [3:0]  be_v    [2];
    logic        ready_v [2];
    logic        rvalid_v[2];
    logic [31:0] rdata_v [2];
    logic        stall_v [2];

    int          wcyc [2] = '{2, 0};
    logic [31:0] mdl [2][1024];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd;

    dm_resp #(.ADDR_W(AW), .WAIT_CYCLES(2)) dut_w2 (
        .clk(clk), .rst(rst), .req(req_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .be(be_v[0]), .ready(ready_v[0]), .rvalid(rvalid_v[0]),
        .rdata(rdata_v[0]), .stall(stall_v[0])
    );

    dm_resp #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .rst(rst), .req(req_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .be(be_v[1]), .ready(ready_v[1]), .rvalid(rvalid_v[1]),
        .rdata(rdata_v[1]), .stall(stall_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_merge(input logic [31:0] old_word,
                                                input logic [31:0] d,
                                                input logic [3:0]  b);
        logic [31:0] r;
        r = old_word;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // One full access on instance k; drop releases req in the first wait cycle,
    // hold leaves req asserted so the next call forms a back-to-back request.
    task automatic access(input int k, input logic w, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          input bit drop, input bit hold, output logic [31:0] got);
        logic [31:0] exp;
        int n;
        @(negedge clk);
        chk("idle_rvalid", 32'(rvalid_v[k]), 32'd0);
        chk("idle_ready", 32'(ready_v[k]), 32'd1);
        req_v[k] = 1'b1; we_v[k] = w; addr_v[k] = a; wdata_v[k] = d; be_v[k] = b;
        #1;
        chk("accept_stall", 32'(stall_v[k]), 32'd1);
        exp = w ? model_merge(mdl[k][a], d, b) : mdl[k][a];
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (drop && n == 1 && wcyc[k] > 0) begin
                req_v[k] = 1'b0;
                $display("protocol: req dropped in WAIT inst=%0d addr=%h", k, a);
            end
            if (!rvalid_v[k]) begin
                chk("wait_stall", 32'(stall_v[k]), 32'd1);
                chk("wait_ready", 32'(ready_v[k]), 32'd0);
            end
        end while (!rvalid_v[k] && n < 40);
        chk("latency", 32'(n), 32'(wcyc[k] + 1));
        chk("resp_rdata", rdata_v[k], exp);
        chk("resp_stall", 32'(stall_v[k]), 32'd0);
        chk("resp_ready", 32'(ready_v[k]), 32'd0);
        if (w) mdl[k][a] = exp;
        got = rdata_v[k];
        $display("inst=%0d %s addr=%h wdata=%h be=%b rdata=%h exp=%h lat=%0d",
                 k, w ? "WR" : "RD", a, d, b, got, exp, n);
        if (!hold) req_v[k] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                if (rvalid_v[k] && ready_v[k]) chk("rvalid_and_ready", 32'd1, 32'd0);
            end
        end
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            req_v[k] = 0; we_v[k] = 0; addr_v[k] = '0; wdata_v[k] = '0; be_v[k] = '0;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", 32'(ready_v[k]), 32'd1);
            chk("rst_rvalid", 32'(rvalid_v[k]), 32'd0);
            chk("rst_rdata", rdata_v[k], 32'd0);
            chk("rst_stall", 32'(stall_v[k]), 32'd0);
        end

        // Give every address the random traffic touches a known value.
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 17; a++)
                access(k, 1'b1, AW'(a), $urandom, 4'hF, 0, 0, rd);

        access(0, 1'b1, 10'h005, 32'hDEADBEEF, 4'b1111, 0, 1, rd);
        chk("wr_deadbeef", rd, 32'hDEADBEEF);
        access(0, 1'b0, 10'h005, 32'h0, 4'b0000, 0, 0, rd);
        chk("rd_deadbeef", rd, 32'hDEADBEEF);

        access(0, 1'b1, 10'h006, 32'h11223344, 4'b1111, 0, 0, rd);
        access(0, 1'b1, 10'h006, 32'hAABBCCDD, 4'b0101, 0, 0, rd);
        chk("be_merge", rd, 32'h11BB33DD);
        access(0, 1'b0, 10'h006, 32'h0, 4'b0000, 0, 0, rd);
        chk("be_merge_rd", rd, 32'h11BB33DD);

        access(0, 1'b1, 10'h007, 32'hCAFEF00D, 4'b1111, 0, 0, rd);
        access(0, 1'b1, 10'h007, 32'h12345678, 4'b0000, 0, 0, rd);
        chk("be_zero", rd, 32'hCAFEF00D);
        access(0, 1'b0, 10'h007, 32'h0, 4'b0000, 0, 0, rd);
        chk("be_zero_rd", rd, 32'hCAFEF00D);

        access(1, 1'b1, 10'h009, 32'h0BADF00D, 4'b1111, 0, 1, rd);
        access(1, 1'b0, 10'h009, 32'h0, 4'b0000, 0, 1, rd);
        chk("w0_rd", rd, 32'h0BADF00D);
        access(1, 1'b0, 10'h009, 32'h0, 4'b0000, 0, 0, rd);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 40; i++) begin
                logic w;
                w = 1'($urandom_range(0, 1));
                access(k, w, AW'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                       w && ($urandom_range(0, 3) == 0), (i != 39) && ($urandom_range(0, 1) == 1), rd);
            end
        end

        // Reset in the middle of a write's wait states must abort the commit.
        access(0, 1'b1, 10'h010, 32'h00000000, 4'b1111, 0, 0, rd);
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 10'h010;
        wdata_v[0] = 32'hFFFF0000; be_v[0] = 4'b1111;
        @(negedge clk);
        chk("pre_abort_stall", 32'(stall_v[0]), 32'd1);
        rst = 1'b0;
        req_v[0] = 1'b0;
        #1;
        chk("abort_ready", 32'(ready_v[0]), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rvalid", 32'(rvalid_v[0]), 32'd0);
        chk("abort_ready2", 32'(ready_v[0]), 32'd1);
        access(0, 1'b0, 10'h010, 32'h0, 4'b0000, 0, 0, rd);
        chk("abort_rd", rd, 32'h00000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_resp.md
Name: dm_resp

Overview:
- Data-memory responder: the memory end of the MEM-stage access interface.
- The MEM stage drives the requests; this block accepts one request at a time through a req/ready handshake.
- Models a configurable wait-state memory: 1K words, byte-write enables, registered read data.
- Raises a stall to the pipeline until each access completes, so the pipeline can later attach slower memory without changing the MEM stage.

Parameters:
- ADDR_W, 10: word-address width; the array holds 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2: wait states inserted between accept and response; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  1  access request from the MEM stage; held until the response.
- we  in  1  1 = write, 0 = read; sampled at accept.
- addr  in  ADDR_W  word address (byte address bits [ADDR_W+1:2]); sampled at accept.
- wdata  in  32  write data; sampled at accept.
- be  in  4  byte enables for writes; be[i] covers wdata[8i+7:8i]; ignored on reads.
- ready  out  1  responder can accept a request this cycle.
- rvalid  out  1  one-cycle pulse: access complete, rdata valid.
- rdata  out  32  read word, or the merged word after a write.
- stall  out  1  pipeline hold request.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - rvalid=0, rdata=0, wait counter=0, latched request fields=0.
  - Array contents are not reset.
  - An access in progress is aborted with no array write, because the write has not yet been committed.
- States: IDLE, WAIT, RESP. Encoding is taken from the package.
- IDLE:
  - ready=1.
  - If req=1, the accept occurs this cycle: latch we/addr/wdata/be.
  - If WAIT_CYCLES=0, next state is RESP. Otherwise load the counter with WAIT_CYCLES and go to WAIT.
- WAIT:
  - ready=0.
  - The counter decrements each cycle.
  - When the counter is 1, the next state is RESP.
  - req is ignored.
- Commit edge (the edge entering RESP):
  - Read: rdata <= mem[addr].
  - Write: mem[addr] <= merge(mem[addr], wdata, be), and rdata <= the merged word.
  - Merge rule: bytes with be[i]=1 take wdata, all other bytes keep the old value.
- RESP:
  - rvalid=1 and ready=0 for exactly one cycle.
  - Next state is IDLE unconditionally, so a new request is accepted no earlier than the following cycle.
- Latency: rvalid is asserted exactly WAIT_CYCLES+1 cycles after the accept cycle. Default: accept at t, rvalid at t+3.
- stall:
  - Combinational: (state==IDLE & req) | (state==WAIT).
  - Low in RESP, so the MEM stage advances on the rvalid cycle.
  - Low in IDLE with no request.
- rdata holds its value outside RESP until the next commit.
- Write with be=0000: the array is unchanged, the handshake and latency are normal, and rdata = the old word.
- Requester drops req while the block is in WAIT: the access still completes and the write is still committed. The requester is required to hold req, so a bench flags this as a protocol error but expects this completion behaviour.
- Read and write back-to-back to the same address: the read returns the newly written data, because commits are strictly ordered.
- rvalid and ready are never both 1.

Decomposition:
- Package dm_resp_pkg:
  - State enum (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - Wait-counter width constant (4).
  - Byte-merge function.
- Sub-module dm_resp_array:
  - Synchronous single-port 2^ADDR_W x 32 array.
  - Byte-enable write and registered read.
  - Instantiated once; the FSM and counter stay in dm_resp.

Test Plan:
- Reset, then write addr=0x005 wdata=0xDEADBEEF be=1111 with WAIT_CYCLES=2 -> stall high for cycles t..t+2, rvalid pulse at t+3 with rdata=0xDEADBEEF; a following read of 0x005 returns 0xDEADBEEF at accept+3.
- Byte enables: address holds 0x11223344; write wdata=0xAABBCCDD be=0101 -> rdata=0x11BB33DD; a subsequent read confirms it.
- WAIT_CYCLES=0 build: read accepted at t -> rvalid at t+1; ready=0 at t+1; the next request is accepted at t+2.
- Back-to-back requests held continuously -> accepts exactly every WAIT_CYCLES+2 cycles; each rvalid is a single cycle; rvalid&ready is never 1.
- Assert rst low during WAIT of a write to 0x010 (old 0x0) -> rvalid=0 and ready=1 after release; a read of 0x010 returns 0x00000000.
- Write be=0000 to an address holding 0xCAFEF00D -> normal rvalid timing, rdata=0xCAFEF00D, contents unchanged.
